// File: rtl/ld_time_pkg.sv
// Shared types and constants for the ld_time scheduler.
package ld_time_pkg;

  localparam int unsigned SW_REG_W          = 32;
  localparam int unsigned TIME_W_DEF        = 64;
  localparam int unsigned LCNT_W_DEF        = 16;
  localparam int unsigned STATUS_CNT_W      = 16;

  localparam int unsigned CTRL_ARM_BIT      = 0;
  localparam int unsigned CTRL_ABORT_BIT    = 1;
  localparam int unsigned STATUS_ARMED_BIT  = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    LOAD  = 2'd2
  } state_t;

endpackage

// File: rtl/ld_time_sched_rise_det.sv
// Single-bit rising-edge detector; history is preloaded with the live input
// during reset so a level that is already high at release never fires.
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise_c
);

  logic din_d;

  // History register, tracks the input during reset as well
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_d <= din;
    end else begin
      din_d <= din;
    end
  end

  assign rise_c = din & ~din_d;

endmodule

// File: rtl/ld_time_sched.sv
// Time-load scheduler: latches a software target time on arm, then loads the
// free-running sample-time counter on the next rising sync edge.
module ld_time_sched
  import ld_time_pkg::*;
#(
  parameter int unsigned TIME_W = TIME_W_DEF,
  parameter int unsigned LCNT_W = LCNT_W_DEF
) (
  input  logic                user_clk,
  input  logic                user_rst_n,
  input  logic [SW_REG_W-1:0] ld_time_msw,
  input  logic [SW_REG_W-1:0] ld_time_lsw,
  input  logic [SW_REG_W-1:0] ld_time_ctrl,
  input  logic                sync_in,
  output logic [TIME_W-1:0]   time_out,
  output logic                ld_pulse,
  output logic                armed,
  output logic [SW_REG_W-1:0] status
);

  state_t              state;
  state_t              state_nxt;
  logic                arm_re_c;
  logic                sync_re_c;
  logic                abort_c;
  logic                shadow_we_c;
  logic                load_c;
  logic [TIME_W-1:0]   shadow;
  logic [LCNT_W-1:0]   load_cnt;
  logic                ctrl_unused;

  assign abort_c     = ld_time_ctrl[CTRL_ABORT_BIT];
  assign ctrl_unused = ^ld_time_ctrl[SW_REG_W-1:2];

  rise_det u_arm_det (
    .clk    (user_clk),
    .rst_n  (user_rst_n),
    .din    (ld_time_ctrl[CTRL_ARM_BIT]),
    .rise_c (arm_re_c)
  );

  rise_det u_sync_det (
    .clk    (user_clk),
    .rst_n  (user_rst_n),
    .din    (sync_in),
    .rise_c (sync_re_c)
  );

  // FSM state register
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort dominates both arm and sync
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (arm_re_c && !abort_c) begin
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (abort_c) begin
          state_nxt = IDLE;
        end else if (sync_re_c) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM outputs; a sync edge in ARMED keeps the old shadow even if re-armed
  always_comb begin
    shadow_we_c = 1'b0;
    load_c      = 1'b0;
    case (state)
      IDLE: begin
        shadow_we_c = arm_re_c & ~abort_c;
      end
      ARMED: begin
        shadow_we_c = arm_re_c & ~abort_c & ~sync_re_c;
      end
      LOAD: begin
        load_c = 1'b1;
      end
      default: begin
        shadow_we_c = 1'b0;
        load_c      = 1'b0;
      end
    endcase
  end

  // Shadow of the software target time
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      shadow <= '0;
    end else if (shadow_we_c) begin
      shadow <= TIME_W'({ld_time_msw, ld_time_lsw});
    end
  end

  // Free-running sample-time counter with synchronous load
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      time_out <= '0;
    end else if (load_c) begin
      time_out <= shadow;
    end else begin
      time_out <= time_out + TIME_W'(1);
    end
  end

  // Load strobe and wrapping load-event counter
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      ld_pulse <= 1'b0;
      load_cnt <= '0;
    end else begin
      ld_pulse <= load_c;
      if (load_c) begin
        load_cnt <= load_cnt + LCNT_W'(1);
      end
    end
  end

  // Armed flag registered from the next state so it tracks the state register
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      armed <= 1'b0;
    end else begin
      armed <= (state_nxt == ARMED);
    end
  end

  // Status word for software readback
  always_comb begin
    status                   = '0;
    status[STATUS_CNT_W-1:0] = STATUS_CNT_W'(load_cnt);
    status[STATUS_ARMED_BIT] = armed;
  end

endmodule

// File: tb/tb_ld_time_sched.sv
// Bench for ld_time_sched: directed stimulus feeding a load-event scoreboard.
module tb_ld_time_sched;

  localparam int unsigned TIME_W = 64;
  localparam int unsigned LCNT_W = 8;
  localparam int unsigned LCNT_MOD = 1 << LCNT_W;

  typedef struct {
    logic [63:0] t;
    logic [15:0] cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       msw;
  logic [31:0]       lsw;
  logic [31:0]       ctrl;
  logic              sync;
  logic [TIME_W-1:0] time_out;
  logic              ld_pulse;
  logic              armed;
  logic [31:0]       status;

  int   checks = 0;
  int   errors = 0;
  int   lcnt_exp = 0;
  exp_t exp_q[$];

  logic        rst_s = 1'b1;
  bit          model_on = 1'b0;
  logic [63:0] model_t = '0;

  ld_time_sched #(.TIME_W(TIME_W), .LCNT_W(LCNT_W)) dut (
    .user_clk     (clk),
    .user_rst_n   (rst_n),
    .ld_time_msw  (msw),
    .ld_time_lsw  (lsw),
    .ld_time_ctrl (ctrl),
    .sync_in      (sync),
    .time_out     (time_out),
    .ld_pulse     (ld_pulse),
    .armed        (armed),
    .status       (status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_load(input logic [63:0] t);
    exp_t e;
    lcnt_exp++;
    e.t   = t;
    e.cnt = 16'(lcnt_exp % LCNT_MOD);
    exp_q.push_back(e);
  endtask

  // Reset as seen by the DUT at each active edge
  always @(posedge clk) rst_s <= rst_n;

  // Monitor: counter model, scoreboard pop on every load strobe
  always @(negedge clk) begin
    exp_t e;
    if (!rst_s) begin
      model_t  = '0;
      model_on = 1'b1;
    end else if (model_on) begin
      if (ld_pulse) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_pulse", 64'(ld_pulse), 64'd0);
          model_t = model_t + 64'd1;
        end else begin
          e = exp_q.pop_front();
          model_t = e.t;
          chk("sb_load_cnt", 64'(status[15:0]), 64'(e.cnt));
        end
      end else begin
        model_t = model_t + 64'd1;
      end
    end
    if (model_on) chk("time_track", time_out, model_t);
  end

  initial begin
    rst_n = 1'b0; msw = '0; lsw = '0; ctrl = '0; sync = 1'b0;

    // 1: reset values, then free run
    step(2);
    @(negedge clk);
    chk("rst_time", time_out, 64'd0);
    chk("rst_armed", 64'(armed), 64'd0);
    chk("rst_pulse", 64'(ld_pulse), 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    rst_n = 1'b1;
    step(10);
    @(negedge clk);
    chk("t1_time10", time_out, 64'd10);
    chk("t1_armed", 64'(armed), 64'd0);
    chk("t1_status", 64'(status), 64'd0);

    // 2: arm with 0x1_00000002, sync 5 cycles later
    msw = 32'h1; lsw = 32'h2; ctrl = 32'h1;
    step();
    @(negedge clk);
    chk("t2_armed", 64'(armed), 64'd1);
    chk("t2_status_armed", 64'(status), 64'h8000_0000);
    step(4);
    sync = 1'b1;
    push_load(64'h1_0000_0002);
    step();
    @(negedge clk);
    chk("t2_no_pulse_yet", 64'(ld_pulse), 64'd0);
    chk("t2_armed_clr", 64'(armed), 64'd0);
    step();
    @(negedge clk);
    chk("t2_latency", 64'(ld_pulse), 64'd1);
    chk("t2_load_val", time_out, 64'h1_0000_0002);
    chk("t2_status", 64'(status), 64'h1);
    step();
    @(negedge clk);
    chk("t2_one_shot", 64'(ld_pulse), 64'd0);
    chk("t2_next_val", time_out, 64'h1_0000_0003);
    sync = 1'b0; ctrl = '0;
    step();

    // 3: abort and sync in the same cycle
    lsw = 32'h40; ctrl = 32'h1;
    step();
    ctrl = 32'h3; sync = 1'b1;
    step();
    @(negedge clk);
    chk("t3_abort_armed", 64'(armed), 64'd0);
    step(3);
    @(negedge clk);
    chk("t3_no_pulse", 64'(ld_pulse), 64'd0);
    chk("t3_cnt_same", 64'(status), 64'h1);
    sync = 1'b0; ctrl = '0;
    step();

    // abort held high swallows an arm edge
    ctrl = 32'h2;
    step();
    ctrl = 32'h3;
    step();
    @(negedge clk);
    chk("abort_blocks_arm", 64'(armed), 64'd0);
    ctrl = 32'h1;
    step();
    @(negedge clk);
    chk("abort_not_deferred", 64'(armed), 64'd0);
    sync = 1'b1;
    step(3);
    sync = 1'b0; ctrl = '0;
    step();

    // 4: re-arm replaces shadow; register changes after arming are ignored
    msw = '0; lsw = 32'h5; ctrl = 32'h1;
    step();
    ctrl = '0; lsw = 32'h9;
    step();
    ctrl = 32'h1;
    step();
    msw = 32'h55; lsw = 32'h77;
    step();
    sync = 1'b1;
    push_load(64'h9);
    step(2);
    @(negedge clk);
    chk("t4_rearm_load", 64'(ld_pulse), 64'd1);
    sync = 1'b0; ctrl = '0;
    step();

    // arm and sync together from IDLE: sync ignored
    msw = '0; lsw = 32'h20; ctrl = 32'h1; sync = 1'b1;
    step();
    @(negedge clk);
    chk("t4_same_idle_armed", 64'(armed), 64'd1);
    step(2);
    @(negedge clk);
    chk("t4_still_armed", 64'(armed), 64'd1);
    sync = 1'b0;
    step();
    sync = 1'b1;
    push_load(64'h20);
    step(2);
    @(negedge clk);
    chk("t4_later_sync_load", 64'(ld_pulse), 64'd1);
    sync = 1'b0; ctrl = '0;
    step();

    // arm and sync together while ARMED: old shadow loads
    lsw = 32'h30; ctrl = 32'h1;
    step();
    ctrl = '0;
    step();
    lsw = 32'h31; ctrl = 32'h1; sync = 1'b1;
    push_load(64'h30);
    step();
    @(negedge clk);
    chk("t4_same_armed_state", 64'(armed), 64'd0);
    step();
    @(negedge clk);
    chk("t4_old_shadow_load", 64'(ld_pulse), 64'd1);
    sync = 1'b0; ctrl = '0;
    step();

    // arm edge during LOAD is ignored
    lsw = 32'h50; ctrl = 32'h1;
    step();
    ctrl = '0; sync = 1'b1;
    push_load(64'h50);
    step();
    ctrl = 32'h1;
    step();
    @(negedge clk);
    chk("load_arm_pulse", 64'(ld_pulse), 64'd1);
    chk("load_arm_ignored", 64'(armed), 64'd0);
    step();
    @(negedge clk);
    chk("load_arm_still_idle", 64'(armed), 64'd0);
    sync = 1'b0; ctrl = '0;
    step();

    // 5: maximum shadow wraps to zero
    msw = 32'hFFFF_FFFF; lsw = 32'hFFFF_FFFF; ctrl = 32'h1;
    step();
    ctrl = '0; sync = 1'b1;
    push_load(64'hFFFF_FFFF_FFFF_FFFF);
    step();
    sync = 1'b0;
    step();
    @(negedge clk);
    chk("t5_load_max", time_out, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    @(negedge clk);
    chk("t5_wrap_zero", time_out, 64'd0);

    // load counter wrap
    begin
      int n;
      n = LCNT_MOD - (lcnt_exp % LCNT_MOD);
      for (int i = 0; i < n; i++) begin
        msw = '0; lsw = 32'(i); ctrl = 32'h1; sync = 1'b0;
        step();
        ctrl = '0; sync = 1'b1;
        push_load(64'(i));
        step();
        sync = 1'b0;
        step();
      end
    end
    @(negedge clk);
    chk("t5_cnt_wrap", 64'(status), 64'd0);

    // 6: levels high through reset release do not fire
    ctrl = 32'h1; sync = 1'b1; rst_n = 1'b0;
    lcnt_exp = 0;
    step(2);
    @(negedge clk);
    chk("t6_rst_time", time_out, 64'd0);
    rst_n = 1'b1;
    step(4);
    @(negedge clk);
    chk("t6_no_arm", 64'(armed), 64'd0);
    chk("t6_status", 64'(status), 64'd0);
    ctrl = '0; sync = 1'b0;
    step();
    lsw = 32'h99; ctrl = 32'h1;
    step();
    @(negedge clk);
    chk("t6_armed", 64'(armed), 64'd1);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("t6_rst_armed", 64'(armed), 64'd0);
    chk("t6_rst_time0", time_out, 64'd0);
    rst_n = 1'b1; ctrl = '0;
    sync = 1'b1;
    step(2);
    sync = 1'b0;
    step(4);

    @(negedge clk);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
